// File: rtl/control_unit.sv
// Hardwired sequencer for the 16-bit accumulator machine: INIT/IDLE/RUN state, 4-bit
// sequence counter, and combinational decode of every datapath control strobe.
module control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic [15:0] IR,
   input  logic [15:0] AC,
   input  logic [15:0] DR,
   input  logic        E,
   input  logic        IEN_out,
   input  logic        R_out,
   input  logic        FGI,
   output logic [2:0]  mux_sel,
   output logic [2:0]  alu_op,
   output logic        mem_we,
   output logic        load_AR,
   output logic        inc_AR,
   output logic        clr_AR,
   output logic        load_PC,
   output logic        inc_PC,
   output logic        clr_PC,
   output logic        load_DR,
   output logic        inc_DR,
   output logic        clr_DR,
   output logic        load_AC,
   output logic        inc_AC,
   output logic        clr_AC,
   output logic        load_E,
   output logic        inc_E,
   output logic        clr_E,
   output logic        load_IEN,
   output logic        inc_IEN,
   output logic        clr_IEN,
   output logic        load_R,
   output logic        inc_R,
   output logic        clr_R,
   output logic        load_start,
   output logic        inc_start,
   output logic        clr_start,
   output logic        load_IR,
   output logic        clr_IR,
   output logic        load_TR,
   output logic        clr_TR,
   output logic [3:0]  sc
);

   typedef enum logic [1:0] {StInit, StIdle, StRun} state_e;

   state_e     state_q, state_d;
   logic [3:0] sc_q, sc_d;
   logic       ind;
   logic       rr_skip;

   assign ind = IR[15];
   assign sc  = sc_q;

   // Skip tests all look at the pre-update AC/E, so they OR freely with any writer.
   assign rr_skip = (IR[4] & ~AC[15]) | (IR[3] & AC[15]) | (IR[2] & (AC == 16'h0000)) |
                    (IR[1] & ~E);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StInit;
         sc_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sc_d       = sc_q;
      mux_sel    = 3'd0;
      alu_op     = 3'd0;
      mem_we     = 1'b0;
      load_AR    = 1'b0;
      inc_AR     = 1'b0;
      clr_AR     = 1'b0;
      load_PC    = 1'b0;
      inc_PC     = 1'b0;
      clr_PC     = 1'b0;
      load_DR    = 1'b0;
      inc_DR     = 1'b0;
      clr_DR     = 1'b0;
      load_AC    = 1'b0;
      inc_AC     = 1'b0;
      clr_AC     = 1'b0;
      load_E     = 1'b0;
      inc_E      = 1'b0;
      clr_E      = 1'b0;
      load_IEN   = 1'b0;
      inc_IEN    = 1'b0;
      clr_IEN    = 1'b0;
      load_R     = 1'b0;
      inc_R      = 1'b0;
      clr_R      = 1'b0;
      load_start = 1'b0;
      inc_start  = 1'b0;
      clr_start  = 1'b0;
      load_IR    = 1'b0;
      clr_IR     = 1'b0;
      load_TR    = 1'b0;
      clr_TR     = 1'b0;

      if (!reset) begin
         unique case (state_q)
            StInit: begin
               clr_AR    = 1'b1;
               clr_PC    = 1'b1;
               clr_DR    = 1'b1;
               clr_AC    = 1'b1;
               clr_E     = 1'b1;
               clr_IR    = 1'b1;
               clr_TR    = 1'b1;
               clr_IEN   = 1'b1;
               clr_R     = 1'b1;
               clr_start = 1'b1;
               sc_d      = 4'd0;
               state_d   = StIdle;
            end
            StIdle: begin
               sc_d = 4'd0;
               if (go) begin
                  inc_start = 1'b1;
                  state_d   = StRun;
               end
            end
            StRun: begin
               sc_d = sc_q + 4'd1;
               if ((sc_q >= 4'd3) && IEN_out && FGI && !R_out) load_R = 1'b1;

               if (R_out && (sc_q <= 4'd2)) begin
                  // Interrupt cycle: save PC at address 0, resume at address 1.
                  case (sc_q)
                     4'd0: begin
                        clr_AR  = 1'b1;
                        mux_sel = 3'd2;
                        load_TR = 1'b1;
                     end
                     4'd1: begin
                        mux_sel = 3'd6;
                        mem_we  = 1'b1;
                        clr_PC  = 1'b1;
                     end
                     default: begin
                        inc_PC  = 1'b1;
                        clr_IEN = 1'b1;
                        clr_R   = 1'b1;
                        sc_d    = 4'd0;
                     end
                  endcase
               end else begin
                  case (sc_q)
                     4'd0: begin
                        mux_sel = 3'd2;
                        load_AR = 1'b1;
                     end
                     4'd1: begin
                        mux_sel = 3'd7;
                        load_IR = 1'b1;
                        inc_PC  = 1'b1;
                     end
                     4'd2: begin
                        mux_sel = 3'd5;
                        load_AR = 1'b1;
                     end
                     4'd3: begin
                        if (IR[14:12] == 3'd7) begin
                           sc_d = 4'd0;
                           if (!ind) begin
                              // Highest-numbered AC writer wins.
                              if (IR[11]) clr_AC = 1'b1;
                              else if (IR[9]) begin
                                 alu_op  = 3'b011;
                                 load_AC = 1'b1;
                              end else if (IR[7]) begin
                                 alu_op  = 3'b100;
                                 load_AC = 1'b1;
                              end else if (IR[6]) begin
                                 alu_op  = 3'b101;
                                 load_AC = 1'b1;
                              end else if (IR[5]) inc_AC = 1'b1;
                              // A rotate can only drive E when the ALU is not busy with CMA.
                              if (IR[10]) clr_E = 1'b1;
                              else if (IR[8]) inc_E = 1'b1;
                              else if (IR[7]) begin
                                 if (!load_AC || (alu_op == 3'b100)) begin
                                    alu_op = 3'b100;
                                    load_E = 1'b1;
                                 end
                              end else if (IR[6]) begin
                                 if (!load_AC || (alu_op == 3'b101)) begin
                                    alu_op = 3'b101;
                                    load_E = 1'b1;
                                 end
                              end
                              inc_PC = rr_skip;
                              if (IR[0]) begin
                                 clr_start = 1'b1;
                                 state_d   = StIdle;
                              end
                           end else begin
                              inc_PC   = IR[9] & FGI;
                              load_IEN = IR[7];
                              clr_IEN  = IR[6];
                           end
                        end else if (ind) begin
                           mux_sel = 3'd7;
                           load_AR = 1'b1;
                        end
                     end
                     4'd4: begin
                        case (IR[14:12])
                           3'd0, 3'd1, 3'd2, 3'd6: begin
                              mux_sel = 3'd7;
                              load_DR = 1'b1;
                           end
                           3'd3: begin
                              mux_sel = 3'd4;
                              mem_we  = 1'b1;
                              sc_d    = 4'd0;
                           end
                           3'd4: begin
                              mux_sel = 3'd1;
                              load_PC = 1'b1;
                              sc_d    = 4'd0;
                           end
                           3'd5: begin
                              mux_sel = 3'd2;
                              mem_we  = 1'b1;
                              inc_AR  = 1'b1;
                           end
                           default: ;
                        endcase
                     end
                     4'd5: begin
                        case (IR[14:12])
                           3'd0: begin
                              alu_op  = 3'b000;
                              load_AC = 1'b1;
                              sc_d    = 4'd0;
                           end
                           3'd1: begin
                              alu_op  = 3'b001;
                              load_AC = 1'b1;
                              load_E  = 1'b1;
                              sc_d    = 4'd0;
                           end
                           3'd2: begin
                              alu_op  = 3'b010;
                              load_AC = 1'b1;
                              sc_d    = 4'd0;
                           end
                           3'd5: begin
                              mux_sel = 3'd1;
                              load_PC = 1'b1;
                              sc_d    = 4'd0;
                           end
                           3'd6: inc_DR = 1'b1;
                           default: ;
                        endcase
                     end
                     4'd6: begin
                        if (IR[14:12] == 3'd6) begin
                           mux_sel = 3'd3;
                           mem_we  = 1'b1;
                           inc_PC  = (DR == 16'h0000);
                           sc_d    = 4'd0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: state_d = StInit;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural datapath and memory driven by the DUT strobes,
// with expected architectural state queued per program and drained at completion points.
module tb_control_unit;

   logic        clk;
   logic        reset;
   logic        go;
   logic [15:0] ir_r, ac_r, dr_r, tr_r;
   logic [11:0] ar_r, pc_r;
   logic        e_r, ien_r, r_r, start_r, fgi;
   logic [15:0] mem [0:4095];

   logic [2:0]  mux_sel, alu_op;
   logic        mem_we;
   logic        load_AR, inc_AR, clr_AR, load_PC, inc_PC, clr_PC, load_DR, inc_DR, clr_DR;
   logic        load_AC, inc_AC, clr_AC, load_E, inc_E, clr_E, load_IEN, inc_IEN, clr_IEN;
   logic        load_R, inc_R, clr_R, load_start, inc_start, clr_start;
   logic        load_IR, clr_IR, load_TR, clr_TR;
   logic [3:0]  sc;

   control_unit dut (
      .clk(clk), .reset(reset), .go(go), .IR(ir_r), .AC(ac_r), .DR(dr_r), .E(e_r),
      .IEN_out(ien_r), .R_out(r_r), .FGI(fgi), .mux_sel(mux_sel), .alu_op(alu_op),
      .mem_we(mem_we), .load_AR(load_AR), .inc_AR(inc_AR), .clr_AR(clr_AR),
      .load_PC(load_PC), .inc_PC(inc_PC), .clr_PC(clr_PC), .load_DR(load_DR),
      .inc_DR(inc_DR), .clr_DR(clr_DR), .load_AC(load_AC), .inc_AC(inc_AC),
      .clr_AC(clr_AC), .load_E(load_E), .inc_E(inc_E), .clr_E(clr_E),
      .load_IEN(load_IEN), .inc_IEN(inc_IEN), .clr_IEN(clr_IEN), .load_R(load_R),
      .inc_R(inc_R), .clr_R(clr_R), .load_start(load_start), .inc_start(inc_start),
      .clr_start(clr_start), .load_IR(load_IR), .clr_IR(clr_IR), .load_TR(load_TR),
      .clr_TR(clr_TR), .sc(sc)
   );

   logic [34:0] all_out;
   logic [9:0]  clr_vec;
   assign all_out = {mux_sel, alu_op, mem_we, load_AR, inc_AR, clr_AR, load_PC, inc_PC,
                     clr_PC, load_DR, inc_DR, clr_DR, load_AC, inc_AC, clr_AC, load_E, inc_E,
                     clr_E, load_IEN, inc_IEN, clr_IEN, load_R, inc_R, clr_R, load_start,
                     inc_start, clr_start, load_IR, clr_IR, load_TR, clr_TR};
   assign clr_vec = {clr_AR, clr_PC, clr_DR, clr_AC, clr_E, clr_IR, clr_TR, clr_IEN, clr_R,
                     clr_start};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [34:0] last_out;
   logic [9:0]  last_clr;
   logic        last_load_r;
   logic [34:0] quiet_acc;

   localparam int unsigned KAc = 0, KE = 1, KPc = 2, KAr = 3, KSc = 4, KMem = 5;
   localparam int unsigned KStart = 6, KIen = 7, KR = 8;

   typedef struct {
      string       tag;
      int unsigned kind;
      logic [11:0] addr;
      logic [15:0] exp;
   } exp_t;
   exp_t sb[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input int unsigned kind, input logic [11:0] addr,
                       input logic [15:0] exp);
      exp_t e;
      e.tag = tag; e.kind = kind; e.addr = addr; e.exp = exp;
      sb.push_back(e);
   endtask

   function automatic logic [15:0] observe(input int unsigned kind, input logic [11:0] addr);
      case (kind)
         KAc:     return ac_r;
         KE:      return {15'h0, e_r};
         KPc:     return {4'h0, pc_r};
         KAr:     return {4'h0, ar_r};
         KSc:     return {12'h0, sc};
         KMem:    return mem[addr];
         KStart:  return {15'h0, start_r};
         KIen:    return {15'h0, ien_r};
         default: return {15'h0, r_r};
      endcase
   endfunction

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, {48'h0, observe(e.kind, e.addr)}, {48'h0, e.exp});
      end
   endtask

   // One clock of the datapath: sample strobes mid-cycle, commit just after the edge.
   task automatic step();
      logic [15:0] bus, alu_y, n_dr, n_ac, n_ir, n_tr, wd;
      logic [11:0] n_ar, n_pc, wa;
      logic        cy, n_e, n_ien, n_r, n_st, we;
      @(negedge clk);
      last_out    = all_out;
      last_clr    = clr_vec;
      last_load_r = load_R;
      case (mux_sel)
         3'd0:    bus = 16'h0;
         3'd1:    bus = {4'h0, ar_r};
         3'd2:    bus = {4'h0, pc_r};
         3'd3:    bus = dr_r;
         3'd4:    bus = ac_r;
         3'd5:    bus = ir_r;
         3'd6:    bus = tr_r;
         default: bus = mem[ar_r];
      endcase
      cy = e_r;
      case (alu_op)
         3'd0:    alu_y = ac_r & dr_r;
         3'd1:    {cy, alu_y} = {1'b0, ac_r} + {1'b0, dr_r};
         3'd2:    alu_y = dr_r;
         3'd3:    alu_y = ~ac_r;
         3'd4:    begin alu_y = {e_r, ac_r[15:1]}; cy = ac_r[0]; end
         3'd5:    begin alu_y = {ac_r[14:0], e_r}; cy = ac_r[15]; end
         default: alu_y = ac_r;
      endcase
      n_ar = clr_AR ? 12'h0 : load_AR ? bus[11:0] : inc_AR ? ar_r + 12'd1 : ar_r;
      n_pc = clr_PC ? 12'h0 : load_PC ? bus[11:0] : inc_PC ? pc_r + 12'd1 : pc_r;
      n_dr = clr_DR ? 16'h0 : load_DR ? bus : inc_DR ? dr_r + 16'd1 : dr_r;
      n_ac = clr_AC ? 16'h0 : load_AC ? alu_y : inc_AC ? ac_r + 16'd1 : ac_r;
      n_e  = clr_E ? 1'b0 : load_E ? cy : inc_E ? ~e_r : e_r;
      n_ir = clr_IR ? 16'h0 : load_IR ? bus : ir_r;
      n_tr = clr_TR ? 16'h0 : load_TR ? bus : tr_r;
      n_ien = clr_IEN ? 1'b0 : load_IEN ? 1'b1 : ien_r;
      n_r   = clr_R ? 1'b0 : load_R ? 1'b1 : r_r;
      n_st  = clr_start ? 1'b0 : inc_start ? 1'b1 : start_r;
      we = mem_we; wa = ar_r; wd = bus;
      @(posedge clk);
      #1;
      ar_r = n_ar; pc_r = n_pc; dr_r = n_dr; ac_r = n_ac; e_r = n_e; ir_r = n_ir;
      tr_r = n_tr; ien_r = n_ien; r_r = n_r; start_r = n_st;
      if (we) mem[wa] = wd;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      go    = 1'b0;
      fgi   = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   task automatic start_run();
      go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int cyc = 0;
      while (start_r && (cyc < max_cyc)) begin
         step();
         cyc++;
      end
      check_eq({tag, "_halted"}, {63'h0, start_r}, 64'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; go = 1'b0; fgi = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      @(posedge clk);
      #1;
      check_eq("rst_outputs", {29'h0, all_out}, 64'h0);
      check_eq("rst_sc", {60'h0, sc}, 64'h0);
      reset = 1'b0;
      step();
      check_eq("init_clears", {54'h0, last_clr}, 64'h3FF);
      step();
      check_eq("idle_quiet", {29'h0, last_out}, 64'h0);

      // CLA then HLT
      do_reset();
      mem[0] = 16'h7800; mem[1] = 16'h7001; ac_r = 16'h1234;
      push("cla_ac", KAc, 0, 16'h0000);
      push("cla_pc", KPc, 0, 16'h0001);
      push("cla_sc", KSc, 0, 16'h0000);
      start_run();
      run_cycles(4);
      drain();
      wait_idle("hlt", 10);
      push("hlt_start", KStart, 0, 16'h0);
      drain();
      quiet_acc = '0;
      repeat (5) begin
         step();
         quiet_acc |= last_out;
      end
      check_eq("hlt_no_strobes", {29'h0, quiet_acc}, 64'h0);
      check_eq("hlt_sc", {60'h0, sc}, 64'h0);

      // ADD with carry out
      do_reset();
      mem[0] = 16'h1010; mem[1] = 16'h7001; mem[12'h010] = 16'hFFFF; ac_r = 16'h0001;
      push("add_ac", KAc, 0, 16'h0000);
      push("add_e", KE, 0, 16'h0001);
      push("add_sc", KSc, 0, 16'h0000);
      start_run();
      run_cycles(6);
      drain();
      wait_idle("add", 10);

      // Indirect LDA
      do_reset();
      mem[0] = 16'hA020; mem[1] = 16'h7001;
      mem[12'h020] = 16'h0030; mem[12'h030] = 16'hBEEF;
      push("lda_ac", KAc, 0, 16'hBEEF);
      push("lda_ar", KAr, 0, 16'h0030);
      push("lda_sc", KSc, 0, 16'h0000);
      start_run();
      run_cycles(6);
      drain();
      wait_idle("lda", 10);

      // ISZ overflow skips the next word
      do_reset();
      mem[0] = 16'h6040; mem[1] = 16'h7800; mem[2] = 16'h7001; mem[12'h040] = 16'hFFFF;
      start_run();
      run_cycles(6);
      push("isz_sc_t6", KSc, 0, 16'h0006);
      drain();
      run_cycles(1);
      push("isz_mem", KMem, 12'h040, 16'h0000);
      push("isz_pc", KPc, 0, 16'h0002);
      push("isz_sc", KSc, 0, 16'h0000);
      drain();
      wait_idle("isz", 10);

      // BSA from PC=5
      do_reset();
      pc_r = 12'h005;
      mem[5] = 16'h5050; mem[12'h051] = 16'h7001;
      push("bsa_mem", KMem, 12'h050, 16'h0006);
      push("bsa_pc", KPc, 0, 16'h0051);
      push("bsa_sc", KSc, 0, 16'h0000);
      start_run();
      run_cycles(6);
      drain();
      wait_idle("bsa", 10);

      // Interrupt request raised during STA T4, serviced at the next T0
      do_reset();
      ien_r = 1'b1; ac_r = 16'h1111;
      mem[0] = 16'h3060; mem[1] = 16'h7001; mem[12'h060] = 16'h0000;
      start_run();
      run_cycles(4);
      fgi = 1'b1;
      step();
      fgi = 1'b0;
      check_eq("irq_load_r", {63'h0, last_load_r}, 64'h1);
      push("sta_mem", KMem, 12'h060, 16'h1111);
      push("irq_r_set", KR, 0, 16'h1);
      push("sta_sc", KSc, 0, 16'h0);
      drain();
      run_cycles(3);
      push("irq_ret_pc", KMem, 12'h000, 16'h0001);
      push("irq_pc", KPc, 0, 16'h0001);
      push("irq_ien", KIen, 0, 16'h0);
      push("irq_r_clr", KR, 0, 16'h0);
      push("irq_sc", KSc, 0, 16'h0);
      drain();
      wait_idle("irq", 10);

      // Register-ref: CMA beats INC, SNA skip, CIL into E, ION
      do_reset();
      ac_r = 16'h00F0; e_r = 1'b0;
      mem[0] = 16'h7220; mem[1] = 16'h7008; mem[2] = 16'h7800;
      mem[3] = 16'h7040; mem[4] = 16'hF080; mem[5] = 16'h7001;
      push("rr_ac", KAc, 0, 16'hFE1E);
      push("rr_e", KE, 0, 16'h1);
      push("rr_pc", KPc, 0, 16'h0006);
      push("rr_ien", KIen, 0, 16'h1);
      start_run();
      wait_idle("rr", 40);
      drain();

      // Reset during STA T4 must not write memory
      do_reset();
      ac_r = 16'h2222;
      mem[0] = 16'h3060; mem[12'h060] = 16'h5A5A;
      start_run();
      run_cycles(4);
      reset = 1'b1;
      #1;
      check_eq("rst_mid_we", {63'h0, mem_we}, 64'h0);
      check_eq("rst_mid_sc", {60'h0, sc}, 64'h0);
      step();
      reset = 1'b0;
      step();
      push("rst_mid_mem", KMem, 12'h060, 16'h5A5A);
      push("rst_mid_pc", KPc, 0, 16'h0000);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
